// File: rtl/branch_resolver.sv
// branch_resolver: carries branch information from fetch through the F/D, D/E
// and E/M pipeline registers, resolves the branch condition in E on the
// forwarded operands, and reports the corrected next PC and a misprediction
// flag in M. A misprediction flushes F/D and D/E. The delay slot in E still
// advances into M.
//
// Optional feature: define BR_STATS_EN to build saturating 32-bit branch and
// misprediction counters. Without it, br_cnt and mis_cnt are constant zero.
module branch_resolver (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        stallE,
    input  logic [31:0] pcF,
    input  logic        pcsrcPF,
    input  logic        branchD,
    input  logic [2:0]  brtypeD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        branchM,
    output logic [31:0] pcM,
    output logic        pcsrcM,
    output logic        pcsrcPM,
    output logic [31:0] fpcM,
    output logic        pmis,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam logic [2:0] BT_BEQ  = 3'b000;
    localparam logic [2:0] BT_BNE  = 3'b001;
    localparam logic [2:0] BT_BLEZ = 3'b010;
    localparam logic [2:0] BT_BGTZ = 3'b011;
    localparam logic [2:0] BT_BLTZ = 3'b100;
    localparam logic [2:0] BT_BGEZ = 3'b101;

    // Branch condition on signed operands; reserved encodings never take.
    function automatic logic eval_taken(input logic [2:0] ty,
                                        input logic signed [31:0] a,
                                        input logic signed [31:0] b);
        logic r;
        case (ty)
            BT_BEQ:  r = (a == b);
            BT_BNE:  r = (a != b);
            BT_BLEZ: r = (a <= 32'sd0);
            BT_BGTZ: r = (a >  32'sd0);
            BT_BLTZ: r = (a <  32'sd0);
            BT_BGEZ: r = (a >= 32'sd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // F/D register
    logic [31:0] fd_pc_q, fd_pc_d;
    logic        fd_pcsrcp_q, fd_pcsrcp_d;

    // D/E register
    logic [31:0] de_pc_q, de_pc_d;
    logic        de_pcsrcp_q, de_pcsrcp_d;
    logic        de_branch_q, de_branch_d;
    logic [2:0]  de_brtype_q, de_brtype_d;
    logic [31:0] de_target_q, de_target_d;

    // E/M register
    logic [31:0] em_pc_q, em_pc_d;
    logic        em_pcsrcp_q, em_pcsrcp_d;
    logic        em_branch_q, em_branch_d;
    logic        em_taken_q, em_taken_d;
    logic [31:0] em_target_q, em_target_d;

    logic taken_e;
    logic pmis_m;

    // Resolve the E-stage branch; a non-branch never reports taken.
    always_comb begin
        taken_e = de_branch_q & eval_taken(de_brtype_q, srcaE, srcbE);
    end

    // Misprediction is purely a function of the M-stage register contents.
    always_comb begin
        pmis_m = em_branch_q & (em_taken_q ^ em_pcsrcp_q);
    end

    // F/D next state: flush on mispredict, hold on stallD, else capture fetch.
    always_comb begin
        fd_pc_d     = fd_pc_q;
        fd_pcsrcp_d = fd_pcsrcp_q;
        if (pmis_m) begin
            fd_pc_d     = 32'd0;
            fd_pcsrcp_d = 1'b0;
        end else if (!stallD) begin
            fd_pc_d     = pcF;
            fd_pcsrcp_d = pcsrcPF;
        end
    end

    // D/E next state: flush on mispredict, hold on stallE, bubble when only D stalls.
    always_comb begin
        de_pc_d     = de_pc_q;
        de_pcsrcp_d = de_pcsrcp_q;
        de_branch_d = de_branch_q;
        de_brtype_d = de_brtype_q;
        de_target_d = de_target_q;
        if (pmis_m || (!stallE && stallD)) begin
            de_pc_d     = 32'd0;
            de_pcsrcp_d = 1'b0;
            de_branch_d = 1'b0;
            de_brtype_d = 3'd0;
            de_target_d = 32'd0;
        end else if (!stallE) begin
            de_pc_d     = fd_pc_q;
            de_pcsrcp_d = fd_pcsrcp_q;
            de_branch_d = branchD;
            de_brtype_d = brtypeD;
            de_target_d = pcbranchD;
        end
    end

    // E/M next state: bubble while E stalls. A mispredict does not touch it,
    // so the delay slot still advances into M.
    always_comb begin
        em_pc_d     = de_pc_q;
        em_pcsrcp_d = de_pcsrcp_q;
        em_branch_d = de_branch_q;
        em_taken_d  = taken_e;
        em_target_d = de_target_q;
        if (stallE) begin
            em_pc_d     = 32'd0;
            em_pcsrcp_d = 1'b0;
            em_branch_d = 1'b0;
            em_taken_d  = 1'b0;
            em_target_d = 32'd0;
        end
    end

    // Pipeline registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            fd_pc_q     <= 32'd0;
            fd_pcsrcp_q <= 1'b0;
            de_pc_q     <= 32'd0;
            de_pcsrcp_q <= 1'b0;
            de_branch_q <= 1'b0;
            de_brtype_q <= 3'd0;
            de_target_q <= 32'd0;
            em_pc_q     <= 32'd0;
            em_pcsrcp_q <= 1'b0;
            em_branch_q <= 1'b0;
            em_taken_q  <= 1'b0;
            em_target_q <= 32'd0;
        end else begin
            fd_pc_q     <= fd_pc_d;
            fd_pcsrcp_q <= fd_pcsrcp_d;
            de_pc_q     <= de_pc_d;
            de_pcsrcp_q <= de_pcsrcp_d;
            de_branch_q <= de_branch_d;
            de_brtype_q <= de_brtype_d;
            de_target_q <= de_target_d;
            em_pc_q     <= em_pc_d;
            em_pcsrcp_q <= em_pcsrcp_d;
            em_branch_q <= em_branch_d;
            em_taken_q  <= em_taken_d;
            em_target_q <= em_target_d;
        end
    end

    assign branchM = em_branch_q;
    assign pcM     = em_pc_q;
    assign pcsrcM  = em_taken_q;
    assign pcsrcPM = em_pcsrcp_q;
    assign pmis    = pmis_m;
    // The not-taken path skips the delay slot; wraps modulo 2^32.
    assign fpcM    = em_taken_q ? em_target_q : (em_pc_q + 32'd8);

`ifdef BR_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Saturating event counters for resolved branches and mispredictions.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (em_branch_q && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (pmis_m && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    // Counter registers; reset also suppresses the update of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;
`else
    assign br_cnt  = 32'd0;
    assign mis_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run, all also checked
// every cycle against a slot-level reference model of the three registers.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst, stallD, stallE, pcsrcPF, branchD;
    logic [31:0] pcF, pcbranchD, srcaE, srcbE;
    logic [2:0]  brtypeD;
    logic        branchM, pcsrcM, pcsrcPM, pmis;
    logic [31:0] pcM, fpcM, br_cnt, mis_cnt;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .rst(rst), .stallD(stallD), .stallE(stallE),
        .pcF(pcF), .pcsrcPF(pcsrcPF), .branchD(branchD), .brtypeD(brtypeD),
        .pcbranchD(pcbranchD), .srcaE(srcaE), .srcbE(srcbE),
        .branchM(branchM), .pcM(pcM), .pcsrcM(pcsrcM), .pcsrcPM(pcsrcPM),
        .fpcM(fpcM), .pmis(pmis), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // One pipeline slot of the reference model.
    typedef struct {
        logic [31:0] pc;
        logic        pp;
        logic        br;
        logic [2:0]  ty;
        logic [31:0] tgt;
        logic        tk;
    } slot_t;

    slot_t       m_fd, m_de, m_em;
    int unsigned m_br = 0, m_mis = 0;

    typedef struct {
        logic        rst, sd, se;
        logic [31:0] pcf;
        logic        pp, bd;
        logic [2:0]  ty;
        logic [31:0] tgt, a, b;
        logic        e_br;
        logic [31:0] e_pc;
        logic        e_tk, e_pp, e_mis;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t tbl[11];

    function automatic logic ref_taken(logic [2:0] ty, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (ty)
            3'd0: return sa == sb;
            3'd1: return sa != sb;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic slot_t empty_slot();
        slot_t s;
        s.pc = 0; s.pp = 0; s.br = 0; s.ty = 0; s.tgt = 0; s.tk = 0;
        return s;
    endfunction

    function automatic logic model_pmis();
        return m_em.br & (m_em.tk ^ m_em.pp);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic sd, input logic se,
                         input logic [31:0] pcf, input logic pp, input logic bd,
                         input logic [2:0] ty, input logic [31:0] tgt,
                         input logic [31:0] a, input logic [31:0] b);
        rst = r; stallD = sd; stallE = se; pcF = pcf; pcsrcPF = pp;
        branchD = bd; brtypeD = ty; pcbranchD = tgt; srcaE = a; srcbE = b;
    endtask

    // Advance model and DUT one clock with the currently driven inputs, then
    // compare every output against the model.
    task automatic step();
        slot_t nfd, nde, nem;
        logic pm;
        int unsigned nbr, nmis;
        pm = model_pmis();
        if (stallE) nem = empty_slot();
        else begin
            nem = m_de;
            nem.tk = m_de.br & ref_taken(m_de.ty, srcaE, srcbE);
        end
        if (pm || (stallD && !stallE)) nde = empty_slot();
        else if (stallE) nde = m_de;
        else begin
            nde = empty_slot();
            nde.pc = m_fd.pc; nde.pp = m_fd.pp; nde.br = branchD;
            nde.ty = brtypeD; nde.tgt = pcbranchD;
        end
        if (pm) nfd = empty_slot();
        else if (stallD) nfd = m_fd;
        else begin
            nfd = empty_slot();
            nfd.pc = pcF; nfd.pp = pcsrcPF;
        end
        nbr  = (m_em.br && m_br != 32'hFFFF_FFFF) ? m_br + 1 : m_br;
        nmis = (pm && m_mis != 32'hFFFF_FFFF) ? m_mis + 1 : m_mis;
        if (rst) begin
            nfd = empty_slot(); nde = empty_slot(); nem = empty_slot();
            nbr = 0; nmis = 0;
        end
        @(posedge clk);
        #1;
        m_fd = nfd; m_de = nde; m_em = nem; m_br = nbr; m_mis = nmis;
        chk("model branchM", {31'd0, branchM}, {31'd0, m_em.br});
        chk("model pcM", pcM, m_em.pc);
        chk("model pcsrcM", {31'd0, pcsrcM}, {31'd0, m_em.tk});
        chk("model pcsrcPM", {31'd0, pcsrcPM}, {31'd0, m_em.pp});
        chk("model fpcM", fpcM, m_em.tk ? m_em.tgt : m_em.pc + 32'd8);
        chk("model pmis", {31'd0, pmis}, {31'd0, model_pmis()});
`ifdef BR_STATS_EN
        chk("model br_cnt", br_cnt, m_br);
        chk("model mis_cnt", mis_cnt, m_mis);
`else
        chk("model br_cnt", br_cnt, 32'd0);
        chk("model mis_cnt", mis_cnt, 32'd0);
`endif
    endtask

    // Idle fetch, branch in D, operands in E, then one drain cycle; checks
    // the resolved direction against a hand-derived constant.
    task automatic issue_branch(input string name, input logic [2:0] ty,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic pp, input logic exp_tk);
        drive(0, 0, 0, 32'h400, pp, 0, 0, 0, 0, 0);               step();
        drive(0, 0, 0, 32'h404, 0, 1, ty, 32'h500, 0, 0);         step();
        drive(0, 0, 0, 32'h408, 0, 0, 0, 0, a, b);                step();
        chk({name, " branchM"}, {31'd0, branchM}, 32'd1);
        chk({name, " pcsrcM"}, {31'd0, pcsrcM}, {31'd0, exp_tk});
        chk({name, " fpcM"}, fpcM, exp_tk ? 32'h500 : 32'h408);
        drive(0, 0, 0, 32'h40C, 0, 0, 0, 0, 0, 0);                step();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_fd = empty_slot(); m_de = empty_slot(); m_em = empty_slot();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //           rst sd se pcF       pp bd ty     tgt       a  b | br pc        tk pp mis fpc
        tbl[0]  = '{1, 0, 0, 32'h000, 0, 0, 3'd0, 32'h000, 0, 0, 0, 32'h000, 0, 0, 0, 32'h008};
        tbl[1]  = '{0, 0, 0, 32'h100, 1, 0, 3'd0, 32'h000, 0, 0, 0, 32'h000, 0, 0, 0, 32'h008};
        tbl[2]  = '{0, 0, 0, 32'h104, 0, 1, 3'd0, 32'h200, 0, 0, 0, 32'h000, 0, 0, 0, 32'h008};
        tbl[3]  = '{0, 0, 0, 32'h108, 0, 0, 3'd0, 32'h000, 5, 5, 1, 32'h100, 1, 1, 0, 32'h200};
        tbl[4]  = '{0, 0, 0, 32'h10C, 0, 0, 3'd0, 32'h000, 0, 0, 0, 32'h104, 0, 0, 0, 32'h10C};
        tbl[5]  = '{0, 0, 0, 32'h100, 1, 0, 3'd0, 32'h000, 0, 0, 0, 32'h108, 0, 0, 0, 32'h110};
        tbl[6]  = '{0, 0, 0, 32'h104, 0, 1, 3'd1, 32'h200, 0, 0, 0, 32'h10C, 0, 0, 0, 32'h114};
        tbl[7]  = '{0, 0, 0, 32'h108, 0, 0, 3'd0, 32'h000, 7, 7, 1, 32'h100, 0, 1, 1, 32'h108};
        tbl[8]  = '{0, 0, 0, 32'h10C, 0, 1, 3'd0, 32'h300, 0, 0, 0, 32'h104, 0, 0, 0, 32'h10C};
        tbl[9]  = '{0, 0, 0, 32'h200, 0, 0, 3'd0, 32'h000, 0, 0, 0, 32'h000, 0, 0, 0, 32'h008};
        tbl[10] = '{0, 0, 0, 32'h204, 0, 0, 3'd0, 32'h000, 0, 0, 0, 32'h000, 0, 0, 0, 32'h008};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].sd, tbl[i].se, tbl[i].pcf, tbl[i].pp, tbl[i].bd,
                  tbl[i].ty, tbl[i].tgt, tbl[i].a, tbl[i].b);
            step();
            chk($sformatf("tbl%0d branchM", i), {31'd0, branchM}, {31'd0, tbl[i].e_br});
            chk($sformatf("tbl%0d pcM", i), pcM, tbl[i].e_pc);
            chk($sformatf("tbl%0d pcsrcM", i), {31'd0, pcsrcM}, {31'd0, tbl[i].e_tk});
            chk($sformatf("tbl%0d pcsrcPM", i), {31'd0, pcsrcPM}, {31'd0, tbl[i].e_pp});
            chk($sformatf("tbl%0d pmis", i), {31'd0, pmis}, {31'd0, tbl[i].e_mis});
            chk($sformatf("tbl%0d fpcM", i), fpcM, tbl[i].e_fpc);
        end

        // Signed and reserved-condition corner cases.
        issue_branch("bgez min", 3'd5, 32'h8000_0000, 0, 0, 1'b0);
        issue_branch("bltz min", 3'd4, 32'h8000_0000, 0, 0, 1'b1);
        issue_branch("blez zero", 3'd2, 32'h0, 0, 0, 1'b1);
        issue_branch("bgtz zero", 3'd3, 32'h0, 0, 0, 1'b0);
        issue_branch("bgtz max", 3'd3, 32'h7FFF_FFFF, 0, 0, 1'b1);
        issue_branch("reserved", 3'd6, 32'h9, 32'h9, 0, 1'b0);
        issue_branch("beq ne", 3'd0, 32'h1, 32'h2, 0, 1'b0);

        // Two stallE cycles with the branch sitting in E.
        drive(0, 0, 0, 32'h600, 1, 0, 0, 0, 0, 0);              step();
        drive(0, 0, 0, 32'h604, 0, 1, 3'd0, 32'h700, 0, 0);     step();
        drive(0, 0, 1, 32'h608, 0, 0, 0, 0, 3, 3);              step();
        chk("stallE 1 branchM", {31'd0, branchM}, 32'd0);
        drive(0, 0, 1, 32'h60C, 0, 0, 0, 0, 3, 3);              step();
        chk("stallE 2 branchM", {31'd0, branchM}, 32'd0);
        drive(0, 0, 0, 32'h610, 0, 0, 0, 0, 3, 3);              step();
        chk("stall release branchM", {31'd0, branchM}, 32'd1);
        chk("stall release pcM", pcM, 32'h600);
        chk("stall release pcsrcM", {31'd0, pcsrcM}, 32'd1);
        chk("stall release fpcM", fpcM, 32'h700);
        chk("stall release pmis", {31'd0, pmis}, 32'd0);

        // Reset while a branch is in E.
        drive(0, 0, 0, 32'h800, 0, 0, 0, 0, 0, 0);              step();
        drive(0, 0, 0, 32'h804, 0, 1, 3'd0, 32'h900, 0, 0);     step();
        drive(1, 0, 0, 32'h808, 0, 0, 0, 0, 4, 4);              step();
        chk("rst branchM", {31'd0, branchM}, 32'd0);
        chk("rst pmis", {31'd0, pmis}, 32'd0);
        chk("rst fpcM", fpcM, 32'h8);
        chk("rst br_cnt", br_cnt, 32'd0);
        chk("rst mis_cnt", mis_cnt, 32'd0);

        // Three branches, exactly one mispredicted.
        issue_branch("cnt a", 3'd0, 32'h5, 32'h5, 1, 1'b1);
        issue_branch("cnt b", 3'd1, 32'h5, 32'h5, 0, 1'b0);
        issue_branch("cnt c", 3'd4, 32'hFFFF_FFFF, 0, 0, 1'b1);
`ifdef BR_STATS_EN
        chk("br_cnt three", br_cnt, 32'd3);
        chk("mis_cnt one", mis_cnt, 32'd1);
        force dut.br_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        m_br = 32'hFFFF_FFFE;
        issue_branch("sat a", 3'd0, 32'h1, 32'h1, 1, 1'b1);
        issue_branch("sat b", 3'd0, 32'h1, 32'h1, 1, 1'b1);
        chk("br_cnt saturated", br_cnt, 32'hFFFF_FFFF);
`else
        chk("br_cnt off", br_cnt, 32'd0);
        chk("mis_cnt off", mis_cnt, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = pick_operand();
            b = ($urandom_range(0, 1) == 0) ? a : pick_operand();
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom, a, b);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
